// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// funct3 size/sign encodings and the default base address.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-enable/store-lane generation and load extraction with sign/zero extension.
// DMEM_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses instead of aligning them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    off      = addr_lo;
    misalign = 1'b0;
    case (funct3[1:0])
      F3_LH[1:0]: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = addr_lo[0];
`else
        off = {addr_lo[1], 1'b0};
`endif
      end
      F3_LW[1:0]: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = |addr_lo;
`else
        off = '0;
`endif
      end
      default: ;
    endcase
  end

  assign shifted = rword >> {off, 3'b000};

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    be    = '0;
    wword = '0;
    rdata = '0;
    case (funct3[1:0])
      F3_LB[1:0]: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_LH[1:0]: begin
        be    = 4'b0011 << off;
        wword = {2{wdata[15:0]}};
        rdata = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_LW[1:0]: begin
        be    = '1;
        wword = wdata;
        rdata = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request, fixed-latency response.
// Misalignment handling is selected by DMEM_MISALIGN_TRAP_EN (see dmem_lane_align).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       AWIDTH      = 32,
  parameter int unsigned       DWIDTH      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(DMEM_BASE_ADDR),
  parameter int unsigned       LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [2:0]        funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned       IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned       CW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [AWIDTH-1:0] SPAN = AWIDTH'(4 * DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;

  logic              accept, in_range, kind_ok, f3_ok, misalign, err;
  logic [AWIDTH-1:0] off;
  logic [IW-1:0]     idx;
  logic [3:0]        be;
  logic [31:0]       wword, ld_data, rword;

  assign accept   = (state_q == IDLE) && req_valid_i;
  assign off      = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && (off < SPAN);
  assign idx      = off[IW+1:2];
  assign rword    = mem[idx];
  assign kind_ok  = memren_i ^ memwren_i;
  assign f3_ok    = memren_i ? load_f3_ok(funct3_i) : store_f3_ok(funct3_i);
  assign err      = !kind_ok || !in_range || !f3_ok || misalign;

  dmem_lane_align u_lane (
    .addr_lo  (addr_i[1:0]),
    .funct3   (funct3_i),
    .wdata    (32'(wdata_i)),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          cnt_d   = '0;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(LATENCY - 2)) state_d = RESP;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The whole response is resolved at acceptance, so later request changes never leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= err;
      rdata_q <= (memren_i && !err) ? DWIDTH'(ld_data) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && memwren_i && !err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rdata_o = rsp_valid_o ? rdata_q : '0;
  assign err_o   = rsp_valid_o & err_q;

endmodule
